// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: FSM states, exception
// causes, RV64 load/store funct3 encodings and byte-lane helpers.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } exc_cause_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Byte enables for an access of the given size sitting in lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load alignment: pulls the addressed lane out of the read doubleword and
// sign- or zero-extends it according to funct3.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   data_o = shifted;
      F3_LBU:  data_o = {56'd0, shifted[7:0]};
      F3_LHU:  data_o = {48'd0, shifted[15:0]};
      F3_LWU:  data_o = {32'd0, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage: issues loads/stores on a req/ack data bus, registers the WB
// result (also the EX forwarding taps) and stalls EX while an access is open.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   wr_ram_data_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [7:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              wb_valid_o,
  output logic              wb_reg_write_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_result_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        lane_q, lane_d;
  logic              rw_q, rw_d;
  logic              load_q, load_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              wbv_q, wbv_d;
  logic              wbrw_q, wbrw_d;
  logic [4:0]        wbrd_q, wbrd_d;
  logic [XLEN-1:0]   wbres_q, wbres_d;
  logic              exc_q, exc_d;
  exc_cause_e        cause_q, cause_d;

  logic              is_mem;
  logic              illegal;
  logic              misaligned;
  logic [XLEN-1:0]   load_data;

  assign is_mem     = mem_read_i | mem_write_i;
  assign illegal    = (mem_read_i & mem_write_i)
                    | (mem_read_i & (funct3_i == 3'b111))
                    | (mem_write_i & funct3_i[2]);
  assign misaligned = (alu_result_i[2:0] & align_mask(funct3_i[1:0])) != 3'b000;

  load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rw_d    = rw_q;
    load_d  = load_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wbv_d   = 1'b0;
    wbrw_d  = 1'b0;
    wbrd_d  = wbrd_q;
    wbres_d = wbres_q;
    exc_d   = 1'b0;
    cause_d = EXC_NONE;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          wbrd_d = rd_i;
          if (!is_mem) begin
            wbv_d   = 1'b1;
            wbrw_d  = reg_write_i;
            wbres_d = alu_result_i;
          end else if (illegal) begin
            wbv_d   = 1'b1;
            wbres_d = alu_result_i;
            exc_d   = 1'b1;
            cause_d = EXC_ILLEGAL;
          end else if (misaligned) begin
            wbv_d   = 1'b1;
            wbres_d = alu_result_i;
            exc_d   = 1'b1;
            cause_d = EXC_MISALIGN;
          end else begin
            rd_d    = rd_i;
            f3_d    = funct3_i;
            lane_d  = alu_result_i[2:0];
            rw_d    = reg_write_i;
            load_d  = mem_read_i;
            req_d   = 1'b1;
            we_d    = mem_write_i;
            addr_d  = {alu_result_i[ADDR_W-1:3], 3'b000};
            be_d    = lane_mask(funct3_i[1:0]) << alu_result_i[2:0];
            wdata_d = mem_write_i ? (wr_ram_data_i << {alu_result_i[2:0], 3'b000}) : '0;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Ack is checked first so a response on the last allowed cycle completes normally.
        if (dmem_ack_i || (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          cnt_d   = '0;
          wbv_d   = 1'b1;
          wbrd_d  = rd_q;
          state_d = ST_IDLE;
          if (dmem_ack_i) begin
            wbrw_d  = load_q & rw_q;
            wbres_d = load_q ? load_data : '0;
          end else begin
            wbres_d = '0;
            exc_d   = 1'b1;
            cause_d = EXC_TIMEOUT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      rw_q    <= 1'b0;
      load_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wbv_q   <= 1'b0;
      wbrw_q  <= 1'b0;
      wbrd_q  <= '0;
      wbres_q <= '0;
      exc_q   <= 1'b0;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rw_q    <= rw_d;
      load_q  <= load_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wbv_q   <= wbv_d;
      wbrw_q  <= wbrw_d;
      wbrd_q  <= wbrd_d;
      wbres_q <= wbres_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  assign stall_o        = (state_q == ST_BUSY);
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign wb_valid_o     = wbv_q;
  assign wb_reg_write_o = wbrw_q;
  assign wb_rd_o        = wbrd_q;
  assign wb_result_o    = wbres_q;
  assign exc_o          = exc_q;
  assign exc_cause_o    = cause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model of the MEM stage with a
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_mem_access_stage;

  localparam int ACK_TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, reg_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [63:0] alu_result_i = '0, wr_ram_data_i = '0, dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic        stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_reg_write_o, exc_o;
  logic [31:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o, wb_result_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  exc_cause_o;

  mem_access_stage #(.XLEN(64), .ADDR_W(32), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .funct3_i(funct3_i),
    .rd_i(rd_i), .alu_result_i(alu_result_i), .wr_ram_data_i(wr_ram_data_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .wb_valid_o(wb_valid_o),
    .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retirement record: {exc, cause[1:0], reg_write, rd[4:0], check_result, result[63:0]}
  logic [73:0] exp_q[$];
  logic [73:0] cur;
  logic        chk_en    = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_store = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [7:0]  exp_be    = '0;
  logic [63:0] exp_wdata = '0;
  logic [7:0]  last_be;
  logic [63:0] last_wdata;

  function automatic logic [73:0] pack(input logic exc, input logic [1:0] cause, input logic rw,
                                       input logic [4:0] rd, input logic chk, input logic [63:0] res);
    return {exc, cause, rw, rd, chk, res};
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] rdata, input int lane, input logic [2:0] f3);
    int nb;
    logic [63:0] mask, v;
    nb   = 1 << f3[1:0];
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v    = (rdata >> (8 * lane)) & mask;
    if (!f3[2] && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk_i) begin
    if (chk_en && rst_i) begin
      check("stall", stall_o, exp_stall);
      check("dmem_req", dmem_req_o, exp_req);
      if (exp_req) begin
        check("dmem_we", dmem_we_o, exp_we);
        check("dmem_addr", dmem_addr_o, exp_addr);
        if (exp_store) begin
          check("dmem_be", dmem_be_o, exp_be);
          check("dmem_wdata", dmem_wdata_o, exp_wdata);
        end
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("wb_valid", wb_valid_o, 1'b1);
        check("wb_rd", wb_rd_o, cur[69:65]);
        check("wb_reg_write", wb_reg_write_o, cur[70]);
        check("exc", exc_o, cur[73]);
        if (cur[73]) check("exc_cause", exc_cause_o, cur[72:71]);
        if (cur[64]) check("wb_result", wb_result_o, cur[63:0]);
      end else begin
        check("wb_valid_idle", wb_valid_o, 1'b0);
        check("exc_idle", exc_o, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus_exp(input logic wr_en, input logic [2:0] f3, input logic [63:0] alu,
                             input logic [63:0] wdata);
    int nb, lane, be_int;
    nb        = 1 << f3[1:0];
    lane      = int'(alu[2:0]);
    be_int    = ((1 << nb) - 1) << lane;
    exp_stall = 1'b1;
    exp_req   = 1'b1;
    exp_we    = wr_en;
    exp_store = wr_en;
    exp_addr  = {alu[31:3], 3'b000};
    exp_be    = be_int[7:0];
    exp_wdata = wdata << (8 * lane);
  endtask

  // Presents one instruction (called just after a rising edge) and plays the
  // memory side; returns just after the edge on which it retires.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic rw, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] wdata,
                        input int ack_at, input logic [63:0] rdata);
    int  nb;
    logic illegal, misal;
    nb      = 1 << f3[1:0];
    illegal = (rd_en && wr_en) || (rd_en && f3 == 3'b111) || (wr_en && f3[2]);
    misal   = (alu % nb) != 0;
    valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; reg_write_i = rw;
    funct3_i = f3; rd_i = rd; alu_result_i = alu; wr_ram_data_i = wdata;
    dmem_ack_i = 1'b0;
    if (!rd_en && !wr_en) begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      exp_q.push_back(pack(1'b0, 2'b00, rw, rd, 1'b1, alu));
    end else if (illegal) begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      exp_q.push_back(pack(1'b1, 2'b11, 1'b0, rd, 1'b0, alu));
    end else if (misal) begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      exp_q.push_back(pack(1'b1, 2'b01, 1'b0, rd, 1'b1, alu));
    end else begin
      @(posedge clk_i); #1;
      set_bus_exp(wr_en, f3, alu, wdata);
      for (int k = 1; k <= ACK_TIMEOUT; k++) begin
        if (k == ack_at) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        end else begin
          dmem_ack_i = 1'b0; dmem_rdata_i = {$urandom, $urandom};
        end
        if (k == 1) begin
          last_be = dmem_be_o; last_wdata = dmem_wdata_o;
        end
        @(posedge clk_i); #1;
        if (k == ack_at) break;
      end
      dmem_ack_i = 1'b0; valid_i = 1'b0;
      exp_stall = 1'b0; exp_req = 1'b0;
      if (ack_at >= 1 && ack_at <= ACK_TIMEOUT)
        exp_q.push_back(pack(1'b0, 2'b00, rd_en & rw, rd, rd_en,
                             rd_en ? load_ext(rdata, int'(alu[2:0]), f3) : 64'd0));
      else
        exp_q.push_back(pack(1'b1, 2'b10, 1'b0, rd, 1'b0, 64'd0));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i    = 1'b0;
      dmem_ack_i = 1'(($urandom_range(0, 1)));
      @(posedge clk_i); #1;
    end
    dmem_ack_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          kind, nb;
  logic        r_rd, r_wr;
  logic [2:0]  r_f3;
  logic [63:0] r_alu;

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_stall", stall_o, 1'b0);
    check("reset_req", dmem_req_o, 1'b0);
    check("reset_wb_valid", wb_valid_o, 1'b0);
    check("reset_exc", exc_o, 1'b0);
    check("reset_wb_result", wb_result_o, 64'd0);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_en = 1'b1;

    // Non-mem op, latency 1
    run_op(1'b0, 1'b0, 1'b1, 3'b000, 5'd5, 64'h1234, 64'd0, 0, 64'd0);
    check("lit_nonmem_result", wb_result_o, 64'h1234);
    check("lit_nonmem_rd", wb_rd_o, 5'd5);
    check("lit_nonmem_stall", stall_o, 1'b0);

    // LB from lane 3, ack on the first request cycle
    run_op(1'b1, 1'b0, 1'b1, 3'b000, 5'd9, 64'h1003, 64'd0, 1, 64'h1122_3344_8066_7788);
    check("lit_lb_result", wb_result_o, 64'hFFFF_FFFF_FFFF_FF80);

    // SH into lane 6
    run_op(1'b0, 1'b1, 1'b1, 3'b001, 5'd3, 64'h2006, 64'hBEEF, 2, 64'd0);
    check("lit_sh_be", last_be, 8'hC0);
    check("lit_sh_wdata_hi", last_wdata[63:48], 16'hBEEF);
    check("lit_sh_reg_write", wb_reg_write_o, 1'b0);

    // Misaligned LW
    run_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd4, 64'h1002, 64'd0, 1, 64'd0);
    check("lit_misal_exc", exc_o, 1'b1);
    check("lit_misal_cause", exc_cause_o, 2'b01);
    check("lit_misal_req", dmem_req_o, 1'b0);

    // Illegal forms
    run_op(1'b1, 1'b1, 1'b1, 3'b011, 5'd6, 64'h4000, 64'd0, 1, 64'd0);
    run_op(1'b1, 1'b0, 1'b1, 3'b111, 5'd6, 64'h4000, 64'd0, 1, 64'd0);
    run_op(1'b0, 1'b1, 1'b0, 3'b100, 5'd6, 64'h4000, 64'd0, 1, 64'd0);
    check("lit_illegal_cause", exc_cause_o, 2'b11);

    // Bus timeout, then ack on the final allowed cycle
    run_op(1'b1, 1'b0, 1'b1, 3'b011, 5'd10, 64'h5000, 64'd0, 0, 64'd0);
    check("lit_timeout_cause", exc_cause_o, 2'b10);
    check("lit_timeout_req", dmem_req_o, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 3'b011, 5'd11, 64'h5008, 64'd0, ACK_TIMEOUT, 64'hCAFE_F00D_1234_5678);
    check("lit_ack255_result", wb_result_o, 64'hCAFE_F00D_1234_5678);
    check("lit_ack255_exc", exc_o, 1'b0);

    // Stray acks while idle
    idle_cycles(4);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind  = $urandom_range(0, 9);
      r_rd  = (kind >= 3 && kind <= 5) || kind == 9;
      r_wr  = (kind >= 6);
      if (r_wr && !r_rd)
        r_f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      else
        r_f3 = 3'($urandom_range(0, 7));
      r_alu = {$urandom, $urandom};
      nb    = 1 << r_f3[1:0];
      if ($urandom_range(0, 2) != 0) r_alu = r_alu - (r_alu % nb);
      run_op(r_rd, r_wr, 1'($urandom_range(0, 1)), r_f3, 5'($urandom_range(0, 31)), r_alu,
             {$urandom, $urandom}, $urandom_range(1, 6), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    // Reset in the middle of an outstanding load
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; reg_write_i = 1'b1;
    funct3_i = 3'b011; rd_i = 5'd7; alu_result_i = 64'h3000;
    @(posedge clk_i); #1;
    set_bus_exp(1'b0, 3'b011, 64'h3000, 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk_en = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    check("rst_mid_req", dmem_req_o, 1'b0);
    check("rst_mid_stall", stall_o, 1'b0);
    check("rst_mid_wb_valid", wb_valid_o, 1'b0);
    valid_i = 1'b0; mem_read_i = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_en = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(posedge clk_i);
    #1;
    dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("late_ack_wb_valid", wb_valid_o, 1'b0);
    check("late_ack_stall", stall_o, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
